fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 SHALL have ports (name direction width meaning):
 clock  in  1  single clock; all state updates on posedge.
 reset_n  in  1  reset, synchronous, active-low.
 start  in  1  begin fetching from IDLE or HALTED.
 halt  in  1  level request to stop fetching.
 branch_taken  in  1  redirect strobe from execute.
 branch_target  in  32  redirect address; bits [1:0] ignored.
 imem_req_valid  out  1  fetch request valid.
 imem_req_ready  in  1  memory accepts request.
 imem_addr  out  32  request address, word aligned.
 imem_resp_valid  in  1  response data valid, exactly one per accepted request.
 imem_resp_data  in  32  returned instruction word.
 instr_valid  out  1  instruction offered to decode.
 instr_ready  in  1  decode accepts instruction.
 instr_data  out  32  held instruction.
 instr_pc  out  32  address of held instruction.
 program_counter_value  out  32  next fetch address.
 is_halted  out  1  high in HALTED.

Function
REQ-003 SHALL implement FSM states IDLE, FETCH, WAIT, HOLD, HALTED.
REQ-004 IDLE/HALTED: start && !halt -> FETCH next cycle; otherwise stay; imem_req_valid and instr_valid low.
REQ-005 FETCH: imem_req_valid=1, imem_addr=request address register; on imem_req_ready -> WAIT.
REQ-006 Request address register SHALL load program_counter_value on FETCH entry and SHALL stay stable while imem_req_valid && !imem_req_ready.
REQ-007 SHALL keep at most one request outstanding.
REQ-008 WAIT: on imem_resp_valid with drop flag clear, capture instr_data/instr_pc, -> HOLD; instr_valid high the following cycle.
REQ-009 WAIT: on imem_resp_valid with drop flag set, discard data, clear drop, -> FETCH (or HALTED per REQ-013).
REQ-010 HOLD: instr_valid=1, data/pc stable; on instr_ready, program_counter_value += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), -> FETCH (or HALTED per REQ-013).
REQ-011 branch_taken in FETCH/WAIT/HOLD SHALL set program_counter_value = {branch_target[31:2],2'b00} next cycle; ignored in IDLE/HALTED.
REQ-012 Redirect effects: in FETCH or WAIT, set drop flag, request continues unchanged; in HOLD, drop held instruction (instr_ready ignored that cycle, no +4), instr_valid low next cycle, -> FETCH.
REQ-013 halt sampled only on transitions into FETCH; if high, go HALTED instead; outstanding request always completes first.
REQ-014 branch_taken and halt together: PC redirect applied, halt still honoured.
REQ-015 Fetch latency: start at cycle N -> imem_req_valid at N+1; response at cycle M -> instr_valid at M+1.
REQ-016 imem_resp_valid outside WAIT SHALL be ignored.

Reset
REQ-017 reset_n low at posedge: state IDLE, program_counter_value=RESET_PC, request address=RESET_PC, drop=0, instr_data=0, instr_pc=0, all valids 0, is_halted=0.
REQ-018 Reset mid-transaction SHALL abandon the outstanding request; the memory is reset by the same reset_n.

Structure
REQ-019 Package fetch_pkg SHALL hold fetch_state_t enum and INSTR_BYTES=4.
REQ-020 Single module, no sub-module; PC, request address, drop flag and instruction holding register implemented inline.

Verification
REQ-021 Reset, start, ready=1, 1-cycle memory: requests at 0x0,0x4,0x8; instr_valid three cycles after start; instr_pc matches.
REQ-022 instr_ready low 5 cycles in HOLD: instr_data/instr_pc stable, no new request, program_counter_value unchanged.
REQ-023 branch_taken target 0x103 while in WAIT: response dropped, next request at 0x100, no instr_valid for old address.
REQ-024 branch_taken in HOLD same cycle as instr_ready: instruction dropped, next request at target, no +4.
REQ-025 halt high during WAIT: response delivered, after instr_ready -> HALTED, is_halted=1, no request; start with halt low resumes at next PC.
REQ-026 PC=32'hFFFF_FFFC consumed -> next request at 0x0; reset_n low during WAIT -> state IDLE, PC=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    // Fetch controller FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } fetch_state_t;

    // Size of one instruction word in bytes; the PC advances by this amount.
    localparam int unsigned INSTR_BYTES = 4;

    // Sequential successor of a fetch address (wraps modulo 2^32).
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one word-aligned memory request at a
// time, holds the returned word for decode, and handles redirects and halt.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. Once valid is raised the offering side keeps valid,
// address and data stable until that transfer edge (a branch redirect is the
// only event allowed to withdraw the held instruction).
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         halt,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_addr,
    input  logic         imem_resp_valid,
    input  logic [31:0]  imem_resp_data,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [31:0]  instr_data,
    output logic [31:0]  instr_pc,
    output logic [31:0]  program_counter_value,
    output logic         is_halted,
    output fetch_state_t dbg_state
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_instr_data;
    logic [31:0] r_instr_pc;
    logic        r_drop;

    logic [31:0] w_pc_next;
    logic        w_active;
    logic        w_redirect;
    logic        w_resp_hit;
    logic        w_drop_eff;
    logic        w_consume;
    logic        w_enter_fetch;
    logic        w_unused;

    // Low target bits are architecturally ignored (word-aligned fetch).
    assign w_unused = ^branch_target[1:0];

    assign w_active   = (r_state == FETCH) || (r_state == WAIT) || (r_state == HOLD);
    assign w_redirect = branch_taken && w_active;
    // A response arriving in the same cycle as a redirect is already stale.
    assign w_resp_hit = (r_state == WAIT) && imem_resp_valid;
    assign w_drop_eff = r_drop || w_redirect;
    // A redirect in HOLD kills the held instruction, so instr_ready is ignored.
    assign w_consume  = (r_state == HOLD) && instr_ready && !branch_taken;
    assign w_enter_fetch = (w_state_next == FETCH) && (r_state != FETCH);

    // Next value of the program counter: redirect beats sequential advance.
    always_comb begin
        w_pc_next = r_pc;
        if (w_redirect) begin
            w_pc_next = {branch_target[31:2], 2'b00};
        end else if (w_consume) begin
            w_pc_next = next_seq_pc(r_pc);
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; halt is only looked at where FETCH would be entered.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, HALTED: begin
                if (start && !halt) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                if (imem_req_ready) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (w_drop_eff) begin
                        w_state_next = halt ? HALTED : FETCH;
                    end else begin
                        w_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branch_taken || instr_ready) begin
                    w_state_next = halt ? HALTED : FETCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath registers: PC, request address, drop flag, held instruction.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_drop       <= 1'b0;
            r_instr_data <= 32'h0;
            r_instr_pc   <= 32'h0;
        end else begin
            r_pc <= w_pc_next;
            if (w_enter_fetch) begin
                r_req_addr <= w_pc_next;
            end
            if (w_resp_hit) begin
                r_drop <= 1'b0;
            end else if (w_redirect && (r_state != HOLD)) begin
                r_drop <= 1'b1;
            end
            if (w_resp_hit && !w_drop_eff) begin
                r_instr_data <= imem_resp_data;
                r_instr_pc   <= r_req_addr;
            end
        end
    end

    // Outputs decoded from the current state and the held registers.
    always_comb begin
        imem_req_valid        = (r_state == FETCH);
        imem_addr             = r_req_addr;
        instr_valid           = (r_state == HOLD);
        instr_data            = r_instr_data;
        instr_pc              = r_instr_pc;
        program_counter_value = r_pc;
        is_halted             = (r_state == HALTED);
        dbg_state             = r_state;
    end

endmodule
